// File: rtl/line_window_reader_pkg.sv
// mid_bram_pkg: definitions shared by the line window reader and its sub-blocks.
// Holds the default image geometry, the reader FSM state encoding, and the
// helper that maps a row number plus a row offset to one of the four banks.
package mid_bram_pkg;

  localparam int BIT_DEPTH_DEF    = 8;
  localparam int IMAGE_WIDTH_DEF  = 28;
  localparam int IMAGE_HEIGHT_DEF = 28;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ROWS = 2'd1,
    READ_ROW  = 2'd2,
    DRAIN     = 2'd3
  } state_t;

  // Rows are stored round-robin, so the bank is the low two bits of the row.
  function automatic logic [1:0] bank_of(input logic [10:0] row, input logic [1:0] offset);
    logic [10:0] w_sum;
    w_sum = row + {9'd0, offset};
    return w_sum[1:0];
  endfunction

endpackage

// File: rtl/line_window_reader_window_shift3.sv
// window_shift3: 3x3 pixel window register.
// Ports:
//   clk, rst            clock and asynchronous active-high clear
//   i_en                shift one new column in
//   i_top/i_mid/i_bot   incoming column (top, middle, bottom row)
//   o_RC                window taps, R = row (0 top), C = column (0 oldest)
// New data enters column 2; older columns move toward column 0.
module window_shift3
  import mid_bram_pkg::*;
#(
  parameter int bit_depth = BIT_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic [bit_depth-1:0] i_top,
  input  logic [bit_depth-1:0] i_mid,
  input  logic [bit_depth-1:0] i_bot,
  output logic [bit_depth-1:0] o_00,
  output logic [bit_depth-1:0] o_01,
  output logic [bit_depth-1:0] o_02,
  output logic [bit_depth-1:0] o_10,
  output logic [bit_depth-1:0] o_11,
  output logic [bit_depth-1:0] o_12,
  output logic [bit_depth-1:0] o_20,
  output logic [bit_depth-1:0] o_21,
  output logic [bit_depth-1:0] o_22
);

  logic [bit_depth-1:0] r_win [3][3];
  logic [bit_depth-1:0] w_col [3];

  assign w_col[0] = i_top;
  assign w_col[1] = i_mid;
  assign w_col[2] = i_bot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          r_win[i][j] <= '0;
        end
      end
    end else if (i_en) begin
      for (int i = 0; i < 3; i++) begin
        r_win[i][0] <= r_win[i][1];
        r_win[i][1] <= r_win[i][2];
        r_win[i][2] <= w_col[i];
      end
    end
  end

  assign o_00 = r_win[0][0];
  assign o_01 = r_win[0][1];
  assign o_02 = r_win[0][2];
  assign o_10 = r_win[1][0];
  assign o_11 = r_win[1][1];
  assign o_12 = r_win[1][2];
  assign o_20 = r_win[2][0];
  assign o_21 = r_win[2][1];
  assign o_22 = r_win[2][2];

endmodule

// File: rtl/line_window_reader.sv
// line_window_reader: reads three consecutive rows out of the four-bank row
// buffer column by column and emits a registered 3x3 window stream.
// Ports:
//   clk, RESET            clock, asynchronous active-high reset
//   start                 level enable; low clears counters and returns to IDLE
//   row_done              pulse: writer finished storing one row
//   in0_q..in3_q          bank read data (one cycle after rden)
//   in0_rden..in3_rden    bank read enables
//   rd_addr               read column address
//   win_00..win_22        window taps (row digit, column digit; column 0 oldest)
//   win_valid             taps valid
//   win_row, win_col      top row / left column of the current window
//   frame_done            pulse after the last window of a frame
//   overrun               sticky: writer overwrote a bank still in use
module line_window_reader
  import mid_bram_pkg::*;
#(
  parameter int bit_depth    = BIT_DEPTH_DEF,
  parameter int image_width  = IMAGE_WIDTH_DEF,
  parameter int image_height = IMAGE_HEIGHT_DEF
) (
  input  logic                 clk,
  input  logic                 RESET,
  input  logic                 start,
  input  logic                 row_done,
  input  logic [bit_depth-1:0] in0_q,
  input  logic [bit_depth-1:0] in1_q,
  input  logic [bit_depth-1:0] in2_q,
  input  logic [bit_depth-1:0] in3_q,
  output logic                 in0_rden,
  output logic                 in1_rden,
  output logic                 in2_rden,
  output logic                 in3_rden,
  output logic [4:0]           rd_addr,
  output logic [bit_depth-1:0] win_00,
  output logic [bit_depth-1:0] win_01,
  output logic [bit_depth-1:0] win_02,
  output logic [bit_depth-1:0] win_10,
  output logic [bit_depth-1:0] win_11,
  output logic [bit_depth-1:0] win_12,
  output logic [bit_depth-1:0] win_20,
  output logic [bit_depth-1:0] win_21,
  output logic [bit_depth-1:0] win_22,
  output logic                 win_valid,
  output logic [10:0]          win_row,
  output logic [11:0]          win_col,
  output logic                 frame_done,
  output logic                 overrun
);

  localparam logic [4:0]  LAST_COL   = 5'(image_width - 1);
  localparam logic [10:0] LAST_ROW   = 11'(image_height - 3);
  localparam logic [10:0] FRAME_ROWS = 11'(image_height);

  state_t               r_state, w_state_nx;
  logic [10:0]          r_rows_avail, r_out_row, w_held;
  logic [4:0]           r_col, r_col_p1;
  logic                 r_drain;
  logic                 r_rd_p1, r_vld_p1, r_vld_p2;
  logic                 r_frame_done, r_overrun;
  logic [10:0]          r_win_row;
  logic [11:0]          r_win_col;
  logic                 w_advance, w_frame_end;
  logic [3:0]           w_rden;
  logic [1:0]           w_bank_top, w_bank_mid, w_bank_bot;
  logic [bit_depth-1:0] w_q [4];

  assign w_held      = r_rows_avail - r_out_row;
  assign w_advance   = (r_state == DRAIN) && r_drain;
  assign w_frame_end = w_advance && (r_out_row == LAST_ROW);
  assign w_bank_top  = bank_of(r_out_row, 2'd0);
  assign w_bank_mid  = bank_of(r_out_row, 2'd1);
  assign w_bank_bot  = bank_of(r_out_row, 2'd2);

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:      if (start)              w_state_nx = WAIT_ROWS;
      WAIT_ROWS: if (w_held >= 11'd3)    w_state_nx = READ_ROW;
      READ_ROW:  if (r_col == LAST_COL)  w_state_nx = DRAIN;
      DRAIN:     if (r_drain)            w_state_nx = WAIT_ROWS;
      default:                           w_state_nx = IDLE;
    endcase
    if (!start) w_state_nx = IDLE;
  end

  // Stage p0: address issue. The three banks holding rows out_row..out_row+2
  // are read; the fourth is left to the writer.
  always_comb begin
    w_rden = 4'b0000;
    if (r_state == READ_ROW) begin
      w_rden[w_bank_top] = 1'b1;
      w_rden[w_bank_mid] = 1'b1;
      w_rden[w_bank_bot] = 1'b1;
    end
  end

  assign in0_rden = w_rden[0];
  assign in1_rden = w_rden[1];
  assign in2_rden = w_rden[2];
  assign in3_rden = w_rden[3];
  assign rd_addr  = r_col;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_rows_avail <= '0;
      r_out_row    <= '0;
      r_col        <= '0;
      r_drain      <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      r_rd_p1      <= 1'b0;
      r_col_p1     <= '0;
      r_vld_p1     <= 1'b0;
      r_vld_p2     <= 1'b0;
      r_win_row    <= '0;
      r_win_col    <= '0;
    end else if (!start) begin
      r_rows_avail <= '0;
      r_out_row    <= '0;
      r_col        <= '0;
      r_drain      <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      r_rd_p1      <= 1'b0;
      r_col_p1     <= '0;
      r_vld_p1     <= 1'b0;
      r_vld_p2     <= 1'b0;
      r_win_row    <= '0;
      r_win_col    <= '0;
    end else begin
      // A row arriving in the same cycle as the wrap still has to be counted.
      if (w_frame_end)
        r_rows_avail <= r_rows_avail - FRAME_ROWS + {10'd0, row_done};
      else if (row_done)
        r_rows_avail <= r_rows_avail + 11'd1;

      if (w_frame_end)    r_out_row <= '0;
      else if (w_advance) r_out_row <= r_out_row + 11'd1;

      if (r_state == READ_ROW) r_col <= (r_col == LAST_COL) ? 5'd0 : r_col + 5'd1;
      else                     r_col <= '0;

      r_drain      <= (r_state == DRAIN) ? ~r_drain : 1'b0;
      r_frame_done <= w_frame_end;

      // held == 3 means all three stored rows are still needed; one more
      // completed row means the writer is moving on to a bank still in use.
      if (row_done && (w_held == 11'd3) && !w_advance) r_overrun <= 1'b1;

      // Stage p1: bank data for column r_col_p1 returns this cycle.
      r_rd_p1  <= (r_state == READ_ROW);
      r_col_p1 <= r_col;
      r_vld_p1 <= (r_state == READ_ROW) && (r_col >= 5'd2);

      // Stage p2: window register holds columns r_col_p1-2 .. r_col_p1.
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_win_row <= r_out_row;
        r_win_col <= {7'd0, r_col_p1} - 12'd2;
      end
    end
  end

  assign w_q[0] = in0_q;
  assign w_q[1] = in1_q;
  assign w_q[2] = in2_q;
  assign w_q[3] = in3_q;

  window_shift3 #(.bit_depth(bit_depth)) u_window (
    .clk   (clk),
    .rst   (RESET),
    .i_en  (r_rd_p1),
    .i_top (w_q[w_bank_top]),
    .i_mid (w_q[w_bank_mid]),
    .i_bot (w_q[w_bank_bot]),
    .o_00  (win_00),
    .o_01  (win_01),
    .o_02  (win_02),
    .o_10  (win_10),
    .o_11  (win_11),
    .o_12  (win_12),
    .o_20  (win_20),
    .o_21  (win_21),
    .o_22  (win_22)
  );

  assign win_valid  = r_vld_p2;
  assign win_row    = r_win_row;
  assign win_col    = r_win_col;
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_line_window_reader.sv
module tb_line_window_reader;

  localparam int W = 28;
  localparam int H = 28;

  logic        clk = 1'b0;
  logic        RESET, start, row_done;
  logic [7:0]  q0, q1, q2, q3;
  logic        rden0, rden1, rden2, rden3;
  logic [4:0]  rd_addr;
  logic [7:0]  w00, w01, w02, w10, w11, w12, w20, w21, w22;
  logic        win_valid, frame_done, overrun;
  logic [10:0] win_row;
  logic [11:0] win_col;

  logic [7:0]  mem [0:3][0:31];
  logic [7:0]  tap [0:2][0:2];
  logic [3:0]  rden_v;

  int total = 0;
  int bad   = 0;
  int fd_cnt = 0;

  always #5 clk = ~clk;

  line_window_reader #(.bit_depth(8), .image_width(W), .image_height(H)) dut (
    .clk(clk), .RESET(RESET), .start(start), .row_done(row_done),
    .in0_q(q0), .in1_q(q1), .in2_q(q2), .in3_q(q3),
    .in0_rden(rden0), .in1_rden(rden1), .in2_rden(rden2), .in3_rden(rden3),
    .rd_addr(rd_addr),
    .win_00(w00), .win_01(w01), .win_02(w02),
    .win_10(w10), .win_11(w11), .win_12(w12),
    .win_20(w20), .win_21(w21), .win_22(w22),
    .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
    .frame_done(frame_done), .overrun(overrun)
  );

  assign rden_v = {rden3, rden2, rden1, rden0};
  assign tap[0][0] = w00; assign tap[0][1] = w01; assign tap[0][2] = w02;
  assign tap[1][0] = w10; assign tap[1][1] = w11; assign tap[1][2] = w12;
  assign tap[2][0] = w20; assign tap[2][1] = w21; assign tap[2][2] = w22;

  // Four-bank BRAM model: data one cycle after rden.
  always @(posedge clk) begin
    if (rden0) q0 <= mem[0][rd_addr];
    if (rden1) q1 <= mem[1][rd_addr];
    if (rden2) q2 <= mem[2][rd_addr];
    if (rden3) q3 <= mem[3][rd_addr];
  end

  always @(negedge clk) if (frame_done) fd_cnt++;

  function automatic logic [7:0] pix(input int r, input int c);
    int v;
    v = r * W + c;
    return v[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic write_row(input int r);
    for (int c = 0; c < W; c++) mem[r % 4][c] = pix(r, c);
    row_done = 1'b1;
    @(negedge clk);
    row_done = 1'b0;
  endtask

  task automatic wait_read(output int ok);
    int t;
    t = 0;
    while (rden_v == 4'b0000 && t < 300) begin
      @(negedge clk);
      t++;
    end
    ok = (rden_v != 4'b0000) ? 1 : 0;
  endtask

  // Follows one output row from READ_ROW entry (cycle 0) to cycle W+2 and
  // checks every bank enable, address and window against the pixel formula.
  task automatic run_row(input int r, output int nwin, output int nerr, output int lat,
                         output logic [7:0] f00, output logic [7:0] f22);
    int ok;
    logic [3:0] mask;
    nwin = 0; nerr = 0; lat = -1; f00 = '0; f22 = '0;
    mask = 4'b0000;
    mask[r % 4] = 1'b1;
    mask[(r + 1) % 4] = 1'b1;
    mask[(r + 2) % 4] = 1'b1;
    wait_read(ok);
    if (ok == 0) nerr++;
    else begin
      for (int c = 0; c < W + 2; c++) begin
        if (c < W) begin
          if (rden_v !== mask || rd_addr !== 5'(c)) nerr++;
        end else if (rden_v !== 4'b0000) nerr++;
        if (win_valid) begin
          if (lat < 0) begin lat = c; f00 = tap[0][0]; f22 = tap[2][2]; end
          if (win_row !== 11'(r) || win_col !== 12'(nwin)) nerr++;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              if (tap[i][j] !== pix(r + i, nwin + j)) nerr++;
          nwin++;
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int nwin, nerr, lat, ok, tot_win, tot_err, rows_ok, busy;
    logic [7:0] f00, f22;

    RESET = 1'b1; start = 1'b0; row_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rden", rden_v, 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_valid", win_valid, 0);
    chk("rst_row", win_row, 0);
    chk("rst_col", win_col, 0);
    chk("rst_w00", w00, 0);
    chk("rst_w22", w22, 0);
    chk("rst_fdone", frame_done, 0);
    chk("rst_ovr", overrun, 0);
    RESET = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);

    // First row of windows
    for (int r = 0; r < 3; r++) begin
      repeat (W) @(negedge clk);
      write_row(r);
    end
    fd_cnt = 0;
    run_row(0, nwin, nerr, lat, f00, f22);
    chk("r0_latency", lat, 4);
    chk("r0_w00", f00, 0);
    chk("r0_w22", f22, 58);
    chk("r0_nwin", nwin, 26);
    chk("r0_err", nerr, 0);

    // Rest of the frame, rows every 40 cycles
    tot_win = 0; tot_err = 0; rows_ok = 0;
    fork
      begin
        for (int r = 3; r < H; r++) begin
          repeat (39) @(negedge clk);
          write_row(r);
        end
      end
      begin
        for (int r = 1; r < H - 2; r++) begin
          run_row(r, nwin, nerr, lat, f00, f22);
          tot_win += nwin;
          tot_err += nerr;
          if (nwin == 26 && lat == 4) rows_ok++;
        end
      end
    join
    chk("frame_windows", tot_win, 25 * 26);
    chk("frame_err", tot_err, 0);
    chk("frame_rows_ok", rows_ok, 25);
    repeat (5) @(negedge clk);
    chk("frame_done_cnt", fd_cnt, 1);
    chk("frame_ovr", overrun, 0);
    busy = 0;
    repeat (50) begin
      @(negedge clk);
      if (rden_v != 4'b0000 || win_valid) busy++;
    end
    chk("idle_after_frame", busy, 0);

    // Overrun, then drop start mid READ_ROW
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int r = 0; r < 3; r++) begin
      repeat (W) @(negedge clk);
      write_row(r);
    end
    wait_read(ok);
    chk("ovr_read_start", ok, 1);
    chk("ovr_before", overrun, 0);
    row_done = 1'b1;
    repeat (4) @(negedge clk);
    row_done = 1'b0;
    chk("ovr_set", overrun, 1);
    repeat (20) @(negedge clk);
    chk("ovr_sticky", overrun, 1);
    chk("ovr_still_valid", win_valid, 1);
    start = 1'b0;
    @(negedge clk);
    chk("stop_rden", rden_v, 0);
    chk("stop_valid", win_valid, 0);
    chk("stop_addr", rd_addr, 0);
    chk("stop_ovr", overrun, 0);
    chk("stop_col", win_col, 0);
    chk("stop_row", win_row, 0);

    // Restart: new frame from row 0
    start = 1'b1;
    for (int r = 0; r < 3; r++) begin
      repeat (W) @(negedge clk);
      write_row(r);
    end
    run_row(0, nwin, nerr, lat, f00, f22);
    chk("restart_latency", lat, 4);
    chk("restart_nwin", nwin, 26);
    chk("restart_err", nerr, 0);

    // Asynchronous reset in DRAIN of row 1
    repeat (3) @(negedge clk);
    write_row(3);
    wait_read(ok);
    chk("r1_read_start", ok, 1);
    chk("r1_rden", rden_v, 4'b1110);
    repeat (W) @(negedge clk);
    chk("drain_valid", win_valid, 1);
    chk("drain_row", win_row, 1);
    #2 RESET = 1'b1;
    #1;
    chk("arst_valid", win_valid, 0);
    chk("arst_w00", w00, 0);
    chk("arst_w22", w22, 0);
    chk("arst_row", win_row, 0);
    chk("arst_col", win_col, 0);
    chk("arst_rden", rden_v, 0);
    chk("arst_fdone", frame_done, 0);
    @(negedge clk);
    RESET = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
